// File: rtl/arya_pkg.sv
// Shared definitions for the barrel-core front end: widths, fetch FSM encoding, NOP.
package arya_pkg;

  localparam int unsigned INST_WIDTH      = 32;
  localparam int unsigned INST_ADDR_WIDTH = 9;
  localparam int unsigned THREAD_BITS     = 2;
  localparam int unsigned NUM_THREADS     = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_DONE = 2'd2
  } fetch_state_t;

  localparam logic [INST_WIDTH-1:0] NOP_INST = '0;

endpackage

// File: rtl/thread_fetch_unit_arbiter.sv
// Combinational round-robin thread picker: first eligible thread after last_issued.
module rr_thread_arbiter #(
  parameter int unsigned THREAD_BITS = arya_pkg::THREAD_BITS,
  parameter int unsigned NUM_THREADS = arya_pkg::NUM_THREADS
) (
  input  logic [NUM_THREADS-1:0] eligible,
  input  logic [THREAD_BITS-1:0] last_issued,
  output logic [THREAD_BITS-1:0] grant,
  output logic                   grant_valid
);
  import arya_pkg::*;

  // Thread ids wrap naturally in THREAD_BITS, so i == NUM_THREADS revisits last_issued.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int unsigned i = 1; i <= NUM_THREADS; i++) begin
      if (!grant_valid && eligible[THREAD_BITS'(last_issued + THREAD_BITS'(i))]) begin
        grant       = THREAD_BITS'(last_issued + THREAD_BITS'(i));
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thread_fetch_unit.sv
// Barrel-core fetch stage: per-thread PCs, round-robin issue, branch redirect, halt retirement.
// Optional FETCH_PERF_CNT_EN adds a saturating delivered-instruction counter (fetch_count_out).
module thread_fetch_unit #(
  parameter int unsigned INST_WIDTH      = arya_pkg::INST_WIDTH,
  parameter int unsigned INST_ADDR_WIDTH = arya_pkg::INST_ADDR_WIDTH,
  parameter int unsigned THREAD_BITS     = arya_pkg::THREAD_BITS,
  parameter int unsigned NUM_THREADS     = arya_pkg::NUM_THREADS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_in,
  input  logic                       stall_in,
  input  logic [NUM_THREADS-1:0]     thread_done_in,
  input  logic                       branch_taken_in,
  input  logic [THREAD_BITS-1:0]     branch_thread_in,
  input  logic [INST_ADDR_WIDTH-1:0] branch_target_in,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr_out,
  input  logic [INST_WIDTH-1:0]      imem_data_in,
  output logic [INST_WIDTH-1:0]      inst_out,
  output logic                       inst_valid_out,
  output logic [THREAD_BITS-1:0]     thread_id_out,
  output logic                       all_done_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                fetch_count_out
`endif
);
  import arya_pkg::*;

  fetch_state_t               state, state_next;
  logic [INST_ADDR_WIDTH-1:0] pc [NUM_THREADS];
  logic [NUM_THREADS-1:0]     done_mask;
  logic [THREAD_BITS-1:0]     last_issued;
  logic [THREAD_BITS-1:0]     grant;
  logic                       grant_valid;
  logic                       fetch;
  logic                       branch_ok;
  logic                       squash;
  logic [INST_ADDR_WIDTH-1:0] addr_q;
  logic                       valid_q;
  logic [THREAD_BITS-1:0]     tid_q;

  rr_thread_arbiter #(
    .THREAD_BITS (THREAD_BITS),
    .NUM_THREADS (NUM_THREADS)
  ) u_arbiter (
    .eligible    (~done_mask),
    .last_issued (last_issued),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH_IDLE: if (start_in)     state_next = FETCH_RUN;
      FETCH_RUN:  if (!grant_valid) state_next = FETCH_DONE;
      FETCH_DONE: state_next = FETCH_DONE;
      default:    state_next = FETCH_IDLE;
    endcase
  end

  // A same-cycle branch on the thread being fetched makes that fetch stale, so it is squashed.
  always_comb begin
    fetch         = (state == FETCH_RUN) && grant_valid && !stall_in;
    branch_ok     = (state == FETCH_RUN) && branch_taken_in && !done_mask[branch_thread_in];
    squash        = branch_ok && (branch_thread_in == grant);
    imem_addr_out = fetch ? pc[grant] : addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++)
        pc[t] <= INST_ADDR_WIDTH'(t << (INST_ADDR_WIDTH - THREAD_BITS));
      done_mask    <= '0;
      last_issued  <= THREAD_BITS'(NUM_THREADS - 1);
      addr_q       <= '0;
      valid_q      <= 1'b0;
      tid_q        <= '0;
      all_done_out <= 1'b0;
    end else begin
      if (state == FETCH_RUN) done_mask <= done_mask | thread_done_in;
      if (fetch) begin
        pc[grant]   <= pc[grant] + 1'b1;
        last_issued <= grant;
      end
      // Later assignment wins: a redirect overrides the same-cycle increment.
      if (branch_ok) pc[branch_thread_in] <= branch_target_in;
      addr_q <= imem_addr_out;
      if (state != FETCH_RUN) begin
        valid_q <= 1'b0;
      end else if (!stall_in) begin
        valid_q <= fetch && !squash;
        if (fetch) tid_q <= grant;
      end
      all_done_out <= (state == FETCH_DONE);
    end
  end

  always_comb begin
    inst_valid_out = valid_q;
    thread_id_out  = tid_q;
    inst_out       = valid_q ? imem_data_in : INST_WIDTH'(NOP_INST);
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fetch_count_out <= '0;
    else if (fetch && !squash && (fetch_count_out != '1))
      fetch_count_out <= fetch_count_out + 1'b1;
  end
`endif

endmodule
